// File: rtl/alu_result_buffer.sv
// -----------------------------------------------------------------------------
// alu_result_buffer
//   In-order result FIFO that sits after the 32-bit ALU. It captures each
//   result together with its opcode and request tag, and presents the oldest
//   entry to the writeback stage. There is a valid/ready handshake on both
//   sides. The buffer also derives a zero flag for the head result.
//
//   Optional build macro: ALU_RESULT_STATS_EN
//     When defined, the block adds two saturating 32-bit counters:
//     stat_retired counts pops and stat_stall counts refused push attempts.
//
// Ports
//   clk, rst                      clock; asynchronous active-high reset
//   in_valid/in_ready             producer handshake (in_ready = !full)
//   in_result/in_opcode/in_tag    entry payload
//   out_valid/out_ready           consumer handshake (out_valid = !empty)
//   out_result/out_opcode/out_tag head entry payload
//   out_zero                      head result == 0
//   count/full/empty              occupancy
//   stat_retired/stat_stall       (ALU_RESULT_STATS_EN only) statistics
// -----------------------------------------------------------------------------
module alu_result_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_result,
    input  logic [2:0]               in_opcode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [2:0]               out_opcode,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_zero,
    output logic [$clog2(DEPTH):0]   count,
`ifdef ALU_RESULT_STATS_EN
    output logic [31:0]              stat_retired,
    output logic [31:0]              stat_stall,
`endif
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = WIDTH + 3 + TAG_W;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic push, pop;

    // Handshake status comes from registered occupancy only. A full buffer
    // therefore refuses a push even in a cycle where the head is popped.
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // The head is read straight from storage. Entries pushed into an empty
    // buffer become visible one edge later, because there is no bypass path.
    assign {out_result, out_opcode, out_tag} = mem_q[rd_ptr_q];
    assign out_zero = (out_result == '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {in_result, in_opcode, in_tag};
            // DEPTH is a power of two, so the natural PW-bit rollover gives
            // the modulo-DEPTH wrap.
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Storage is cleared so the outputs read as zero after reset.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef ALU_RESULT_STATS_EN
    logic [31:0] stat_retired_q, stat_retired_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Both counters saturate at all-ones instead of wrapping.
    always_comb begin
        stat_retired_d = stat_retired_q;
        stat_stall_d   = stat_stall_q;
        if (pop && (stat_retired_q != '1))
            stat_retired_d = stat_retired_q + 32'd1;
        if (in_valid && !in_ready && (stat_stall_q != '1))
            stat_stall_d = stat_stall_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_retired_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            stat_retired_q <= stat_retired_d;
            stat_stall_q   <= stat_stall_d;
        end
    end

    assign stat_retired = stat_retired_q;
    assign stat_stall   = stat_stall_q;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_alu_result_buffer
//   Testbench for alu_result_buffer. A queue-based reference FIFO tracks
//   accepted entries. A negedge monitor compares the DUT outputs and
//   occupancy against that reference model. Directed sequences and random
//   traffic drive the stimulus.
// -----------------------------------------------------------------------------
module tb_alu_result_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_result = '0;
    logic [2:0]       in_opcode = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic [2:0]       out_opcode;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic [$clog2(DEPTH):0] count;
    logic             full;
    logic             empty;
`ifdef ALU_RESULT_STATS_EN
    logic [31:0]      stat_retired;
    logic [31:0]      stat_stall;
`endif

    alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_opcode(in_opcode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_opcode(out_opcode), .out_tag(out_tag),
        .out_zero(out_zero), .count(count),
`ifdef ALU_RESULT_STATS_EN
        .stat_retired(stat_retired), .stat_stall(stat_stall),
`endif
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model + monitor ----------------
    typedef struct {
        logic [WIDTH-1:0] r;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t mq[$];
    int   sz_m;
    bit   acc_m;
    longint ret_m, stall_m;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            ret_m   = 0;
            stall_m = 0;
        end else begin
            sz_m = mq.size();
            chk("count", 64'(count), 64'(sz_m));
            chk("full", 64'(full), 64'(sz_m == DEPTH));
            chk("empty", 64'(empty), 64'(sz_m == 0));
            chk("in_ready", 64'(in_ready), 64'(sz_m < DEPTH));
            chk("out_valid", 64'(out_valid), 64'(sz_m > 0));
            if (sz_m > 0) begin
                chk("out_result", 64'(out_result), 64'(mq[0].r));
                chk("out_opcode", 64'(out_opcode), 64'(mq[0].op));
                chk("out_tag", 64'(out_tag), 64'(mq[0].tag));
                chk("out_zero", 64'(out_zero), 64'(mq[0].r == 0));
            end
`ifdef ALU_RESULT_STATS_EN
            chk("stat_retired", 64'(stat_retired), 64'(ret_m));
            chk("stat_stall", 64'(stat_stall), 64'(stall_m));
`endif
            // A full buffer refuses the push even when the head leaves.
            acc_m = in_valid && (sz_m < DEPTH);
            if (in_valid && sz_m >= DEPTH) stall_m++;
            if (sz_m > 0 && out_ready) begin
                void'(mq.pop_front());
                ret_m++;
            end
            if (acc_m) mq.push_back('{r: in_result, op: in_opcode, tag: in_tag});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [WIDTH-1:0] r, input logic [2:0] op,
                         input logic [TAG_W-1:0] t, input bit rdy);
        in_valid  = v;
        in_result = r;
        in_opcode = op;
        in_tag    = t;
        out_ready = rdy;
        cyc();
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [WIDTH-1:0] rv;

    initial begin
        #2;
        chk("rst_count", 64'(count), 0);
        chk("rst_empty", 64'(empty), 1);
        chk("rst_full", 64'(full), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_result", 64'(out_result), 0);
        chk("rst_out_zero", 64'(out_zero), 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fill to full with the consumer stalled, then try one more.
        for (int i = 0; i < 4; i++)
            drive(1, WIDTH'(32'h11 * (i + 1)), 3'(i), TAG_W'(i), 0);
        chk("fill_count", 64'(count), 4);
        chk("fill_full", 64'(full), 1);
        chk("fill_in_ready", 64'(in_ready), 0);
        drive(1, 32'h55, 3'd5, 4'd4, 0);
        chk("refused_count", 64'(count), 4);

        // Drain in order.
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("drain_result", 64'(out_result), 64'(32'h11 * (i + 1)));
            chk("drain_tag", 64'(out_tag), 64'(i));
            drive(0, 0, 0, 0, 1);
        end
        chk("drain_empty", 64'(empty), 1);
        chk("drain_out_valid", 64'(out_valid), 0);

        // Streaming across the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            drive(1, WIDTH'(32'h100 + i), 3'd1, TAG_W'(i), 1);
            chk("stream_count", 64'(count), 1);
            chk("stream_head", 64'(out_result), 64'(32'h100 + i));
        end
        drive(0, 0, 0, 0, 1);
        chk("stream_end_empty", 64'(empty), 1);

        // Zero flag on compare results.
        drive(1, 32'd0, 3'b011, 4'd7, 0);
        drive(1, 32'd1, 3'b011, 4'd8, 0);
        in_valid = 0;
        chk("zero_flag0", 64'(out_zero), 1);
        chk("zero_op0", 64'(out_opcode), 3);
        drive(0, 0, 0, 0, 1);
        chk("zero_flag1", 64'(out_zero), 0);
        chk("zero_op1", 64'(out_opcode), 3);
        drive(0, 0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
            drive(bit'($urandom_range(0, 1)), rv, 3'($urandom), TAG_W'($urandom),
                  bit'($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset in the middle of a cycle.
        do_reset();
        for (int i = 0; i < 3; i++)
            drive(1, WIDTH'(32'hC0 + i), 3'd2, TAG_W'(i), 0);
        in_valid = 0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 0);
        chk("arst_count", 64'(count), 0);
        chk("arst_out_result", 64'(out_result), 0);
        chk("arst_in_ready", 64'(in_ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1, 32'hAB, 3'd4, 4'd9, 0);
        in_valid = 0;
        chk("post_rst_head", 64'(out_result), 32'hAB);
        chk("post_rst_valid", 64'(out_valid), 1);

`ifdef ALU_RESULT_STATS_EN
        do_reset();
        for (int i = 0; i < 4; i++)
            drive(1, WIDTH'(i + 1), 3'd0, TAG_W'(i), 0);
        drive(1, 32'h77, 3'd0, 4'd0, 0);
        drive(1, 32'h78, 3'd0, 4'd0, 0);
        in_valid = 0;
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1);
        out_ready = 0;
        cyc();
        chk("stat_retired3", 64'(stat_retired), 3);
        chk("stat_stall2", 64'(stat_stall), 2);
        do_reset();
        chk("stat_retired_rst", 64'(stat_retired), 0);
        chk("stat_stall_rst", 64'(stat_stall), 0);
`endif

        cyc();
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
